instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit: PC, IR/IR-past, memory read handshake
//
// Ports:
//   clk_i, rstn_i           clock (rising edge), asynchronous active-low reset
//   IRWrite_i               fetch request pulse, honoured only in IDLE
//   PCWrite_i, PCNext_i     PC update; deferred to a pending register while busy
//   mem_req_o, mem_addr_o   read request / address (request only in REQ)
//   mem_gnt_i               request accepted
//   mem_rvalid_i, mem_rdata_i  read data return, honoured only in WAIT
//   Instr_o, InstrPast_o    current / previous instruction
//   PC_o, OldPC_o           program counter / PC of the instruction in Instr_o
//   busy_o, done_o, err_o   stall, one-cycle completion pulse, sticky error
module instr_fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            IRWrite_i,
  input  logic            PCWrite_i,
  input  logic [XLEN-1:0] PCNext_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] Instr_o,
  output logic [XLEN-1:0] InstrPast_o,
  output logic [XLEN-1:0] PC_o,
  output logic [XLEN-1:0] OldPC_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_RESET = XLEN'(RESET_PC);
  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_past_q, instr_past_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            busy;

  assign busy = (state_q == REQ) || (state_q == WAIT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      old_pc_q     <= PC_RESET;
      instr_q      <= NOP;
      instr_past_q <= NOP;
      addr_q       <= PC_RESET;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      old_pc_q     <= old_pc_d;
      instr_q      <= instr_d;
      instr_past_q <= instr_past_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    old_pc_d     = old_pc_q;
    instr_d      = instr_q;
    instr_past_d = instr_past_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (IRWrite_i) begin
          // Latch the pre-update PC so a same-edge PCWrite cannot move the fetch.
          addr_d = pc_q;
          err_d  = 1'b0;
          if (pc_q[1:0] == 2'b00) begin
            state_d = REQ;
          end else begin
            state_d      = ERR;
            instr_d      = NOP;
            instr_past_d = instr_q;
            err_d        = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_rvalid_i) begin
          state_d      = DONE;
          instr_d      = mem_rdata_i;
          instr_past_d = instr_q;
          old_pc_d     = addr_q;
        end else if (cnt_q == TMO_LAST) begin
          state_d      = ERR;
          instr_d      = NOP;
          instr_past_d = instr_q;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        if (pend_vld_q) begin
          pc_d       = pend_q;
          pend_vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A direct write while not busy is newer than any pending value, so it wins.
    if (PCWrite_i) begin
      if (busy) begin
        pend_d     = PCNext_i;
        pend_vld_d = 1'b1;
      end else begin
        pc_d = PCNext_i;
      end
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_addr_o  = (state_q == REQ) ? addr_q : pc_q;
  assign busy_o      = busy;
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign Instr_o     = instr_q;
  assign InstrPast_o = instr_past_q;
  assign PC_o        = pc_q;
  assign OldPC_o     = old_pc_q;

endmodule
